// File: rtl/lc3b_mem_port.sv
// lc3b_mem_port: bridges LC-3b MAR/MDR requests onto a word-only physical memory.
// Byte stores become read-modify-write sequences when RMW_EN is set; completion
// is reported back to the control FSM as a single-cycle mem_resp pulse.
module lc3b_mem_port #(
  parameter bit RMW_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_resp
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

  state_t      state;
  state_t      next_state;
  logic [15:1] addr_q;
  logic [15:0] wdata_q;
  logic [1:0]  be_q;
  logic [15:0] wbuf_q;
  logic [15:0] rdata_q;
  logic [15:0] merged;
  logic        accept;
  logic        unused_addr_bit;

  // Physical memory is word addressed, so the byte-select bit is never needed.
  assign unused_addr_bit = mem_address[0];

  // A request is only taken from IDLE; RESP deliberately ignores held strobes.
  assign accept = (state == IDLE) && (mem_read || mem_write);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection; strobes and mem_resp decode from state only.
  always_comb begin
    next_state = state;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    mem_resp   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_write) begin
          if (mem_byte_enable == 2'b00) begin
            next_state = RESP;
          end else if (RMW_EN && (mem_byte_enable != 2'b11)) begin
            next_state = RMW_RD;
          end else begin
            next_state = WR;
          end
        end else if (mem_read) begin
          next_state = RD;
        end
      end
      RD: begin
        pmem_read = 1'b1;
        if (pmem_resp) next_state = RESP;
      end
      RMW_RD: begin
        pmem_read = 1'b1;
        if (pmem_resp) next_state = WR;
      end
      WR: begin
        pmem_write = 1'b1;
        if (pmem_resp) next_state = RESP;
      end
      RESP: begin
        mem_resp   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Enabled lanes come from the captured store data, the rest from memory.
  always_comb begin
    merged = pmem_rdata;
    if (be_q[1]) merged[15:8] = wdata_q[15:8];
    if (be_q[0]) merged[7:0]  = wdata_q[7:0];
  end

  // Request capture, write-buffer merge and read-data holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= mem_address[15:1];
        if (mem_write) begin
          wdata_q <= mem_wdata;
          be_q    <= mem_byte_enable;
          wbuf_q  <= mem_wdata;
        end
      end
      if ((state == RMW_RD) && pmem_resp) begin
        wbuf_q <= merged;
      end
      if ((state == RD) && pmem_resp) begin
        rdata_q <= pmem_rdata;
      end
    end
  end

  assign pmem_address = {addr_q, 1'b0};
  assign pmem_wdata   = wbuf_q;
  assign mem_rdata    = rdata_q;

endmodule

// File: tb/tb_lc3b_mem_port.sv
// tb_lc3b_mem_port: directed scoreboard bench for lc3b_mem_port.
// Instance 0 uses read-modify-write for byte stores, instance 1 writes them directly.
module tb_lc3b_mem_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read   [2];
  logic        mem_write  [2];
  logic [1:0]  be         [2];
  logic [15:0] maddr      [2];
  logic [15:0] mwdata     [2];
  logic [15:0] mrdata     [2];
  logic        mresp      [2];
  logic        pread      [2];
  logic        pwrite     [2];
  logic [15:0] paddr      [2];
  logic [15:0] pwdata     [2];
  logic [15:0] prdata     [2];
  logic        presp      [2];

  // pmem model controls
  int          lat        [2];
  logic        hold_w     [2];
  logic        force_resp [2];
  int          wait_cnt   [2];
  logic [15:0] mem        [2][64];
  logic        pl_en;
  int          pl_inst;
  logic [15:0] pl_addr;
  logic [15:0] pl_data;

  int cyc    = 0;
  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    int          inst;
    logic [15:0] addr;
    logic [15:0] data;
    int          at;
  } exp_t;

  exp_t rd_q[$];
  exp_t wr_q[$];
  exp_t resp_q[$];

  lc3b_mem_port #(.RMW_EN(1'b1)) dut_rmw (
    .clk(clk), .reset(reset),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_byte_enable(be[0]),
    .mem_address(maddr[0]), .mem_wdata(mwdata[0]), .mem_rdata(mrdata[0]), .mem_resp(mresp[0]),
    .pmem_read(pread[0]), .pmem_write(pwrite[0]), .pmem_address(paddr[0]),
    .pmem_wdata(pwdata[0]), .pmem_rdata(prdata[0]), .pmem_resp(presp[0])
  );

  lc3b_mem_port #(.RMW_EN(1'b0)) dut_direct (
    .clk(clk), .reset(reset),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_byte_enable(be[1]),
    .mem_address(maddr[1]), .mem_wdata(mwdata[1]), .mem_rdata(mrdata[1]), .mem_resp(mresp[1]),
    .pmem_read(pread[1]), .pmem_write(pwrite[1]), .pmem_address(paddr[1]),
    .pmem_wdata(pwdata[1]), .pmem_rdata(prdata[1]), .pmem_resp(presp[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] idx(input logic [15:0] a);
    return {a[14:12], a[3:1]};
  endfunction

  // pmem responder: answers after lat[i] strobe cycles, writes can be stalled
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      presp[i]  = force_resp[i] |
                  ((pread[i] | (pwrite[i] & ~hold_w[i])) & (wait_cnt[i] >= lat[i]));
      prdata[i] = mem[i][idx(paddr[i])];
    end
  end

  // pmem storage, latency counters and preload port
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if ((pread[i] | pwrite[i]) & ~presp[i]) wait_cnt[i] <= wait_cnt[i] + 1;
      else                                    wait_cnt[i] <= 0;
      if (pwrite[i] & presp[i]) mem[i][idx(paddr[i])] <= pwdata[i];
    end
    if (pl_en) mem[pl_inst][idx(pl_addr)] <= pl_data;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a pmem handshake or mem_resp appears
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (pread[i] && presp[i]) begin
        checkOutput("read expected", 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) begin
          e = rd_q.pop_front();
          checkOutput("read inst", i, e.inst);
          checkOutput("read addr", 32'(paddr[i]), 32'(e.addr));
        end
      end
      if (pwrite[i] && presp[i]) begin
        checkOutput("write expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          e = wr_q.pop_front();
          checkOutput("write inst", i, e.inst);
          checkOutput("write addr/data", {paddr[i], pwdata[i]}, {e.addr, e.data});
        end
      end
      if (mresp[i]) begin
        checkOutput("resp expected", 32'(resp_q.size() != 0), 32'd1);
        if (resp_q.size() != 0) begin
          e = resp_q.pop_front();
          checkOutput("resp inst", i, e.inst);
          checkOutput("resp rdata", 32'(mrdata[i]), 32'(e.data));
          checkOutput("resp cycle", cyc, e.at);
        end
      end
    end
  end

  task automatic preload(input int inst, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_inst = inst; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic expectRead(input int inst, input logic [15:0] a);
    exp_t e;
    e.inst = inst; e.addr = a; e.data = 16'h0; e.at = 0;
    rd_q.push_back(e);
  endtask

  task automatic expectWrite(input int inst, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e.inst = inst; e.addr = a; e.data = d; e.at = 0;
    wr_q.push_back(e);
  endtask

  task automatic waitResp(input int inst);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (mresp[inst]) seen = 1'b1;
    end
    checkOutput("resp within bound", 32'(seen), 32'd1);
  endtask

  task automatic dropInputs(input int inst);
    mem_read[inst]  = 1'b0;
    mem_write[inst] = 1'b0;
    be[inst]        = 2'b00;
  endtask

  // Issue one CPU request, hold it until mem_resp (optionally one cycle longer)
  task automatic applyStimulus(input int inst, input logic rd, input logic wr,
                               input logic [1:0] b, input logic [15:0] a,
                               input logic [15:0] d, input int lat_exp,
                               input logic [15:0] rdata_exp, input bit extra);
    exp_t e;
    int n;
    @(posedge clk); #1;
    mem_read[inst] = rd; mem_write[inst] = wr; be[inst] = b;
    maddr[inst] = a; mwdata[inst] = d;
    n = cyc;
    e.inst = inst; e.addr = a; e.data = rdata_exp; e.at = n + lat_exp;
    resp_q.push_back(e);
    if (extra) begin
      e.at = n + lat_exp + 1 + lat_exp;
      resp_q.push_back(e);
    end
    waitResp(inst);
    if (extra) begin
      @(posedge clk);
      @(posedge clk); #1;
      dropInputs(inst);
      waitResp(inst);
    end else begin
      dropInputs(inst);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    reset = 1'b1;
    pl_en = 1'b0; pl_inst = 0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 2; i++) begin
      mem_read[i] = 1'b0; mem_write[i] = 1'b0; be[i] = 2'b00;
      maddr[i] = '0; mwdata[i] = '0;
      lat[i] = 0; hold_w[i] = 1'b0; force_resp[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset values on both instances
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput("reset mem_resp", 32'(mresp[i]), 32'd0);
      checkOutput("reset pmem_read", 32'(pread[i]), 32'd0);
      checkOutput("reset pmem_write", 32'(pwrite[i]), 32'd0);
      checkOutput("reset mem_rdata", 32'(mrdata[i]), 32'h0);
      checkOutput("reset pmem_address", 32'(paddr[i]), 32'h0);
      checkOutput("reset pmem_wdata", 32'(pwdata[i]), 32'h0);
    end

    preload(0, 16'h3004, 16'hBEEF);
    preload(0, 16'h2000, 16'hAABB);
    preload(0, 16'h5000, 16'h1111);
    preload(1, 16'h2000, 16'hAABB);

    // read of an odd address, memory answers one cycle after the strobe
    $display("[TB] read 0x3005");
    lat[0] = 1;
    expectRead(0, 16'h3004);
    applyStimulus(0, 1'b1, 1'b0, 2'b00, 16'h3005, 16'h0, 3, 16'hBEEF, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("rdata held", 32'(mrdata[0]), 32'hBEEF);

    // full-word write, zero-latency memory
    $display("[TB] full write 0x1000");
    lat[0] = 0;
    expectWrite(0, 16'h1000, 16'h1234);
    applyStimulus(0, 1'b0, 1'b1, 2'b11, 16'h1000, 16'h1234, 2, 16'hBEEF, 1'b0);

    // upper-byte store becomes read-modify-write
    $display("[TB] RMW byte write 0x2001");
    expectRead(0, 16'h2000);
    expectWrite(0, 16'h2000, 16'h55BB);
    applyStimulus(0, 1'b0, 1'b1, 2'b10, 16'h2001, 16'h5500, 3, 16'hBEEF, 1'b0);

    // store with no lanes enabled completes without touching memory
    $display("[TB] empty byte-enable write");
    applyStimulus(0, 1'b0, 1'b1, 2'b00, 16'h6000, 16'hFFFF, 1, 16'hBEEF, 1'b0);

    // read and write together, CPU keeps strobes one cycle past mem_resp
    $display("[TB] simultaneous read+write with late strobe drop");
    expectWrite(0, 16'h4000, 16'h0F0F);
    expectWrite(0, 16'h4000, 16'h0F0F);
    applyStimulus(0, 1'b1, 1'b1, 2'b11, 16'h4000, 16'h0F0F, 2, 16'hBEEF, 1'b1);

    // merged word landed in memory
    $display("[TB] read back merged word");
    expectRead(0, 16'h2000);
    applyStimulus(0, 1'b1, 1'b0, 2'b00, 16'h2000, 16'h0, 2, 16'h55BB, 1'b0);

    // reset while the RMW write phase is stalled
    $display("[TB] reset during stalled RMW write");
    hold_w[0] = 1'b1;
    expectRead(0, 16'h5000);
    @(posedge clk); #1;
    mem_write[0] = 1'b1; be[0] = 2'b01; maddr[0] = 16'h5000; mwdata[0] = 16'h00CC;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (pwrite[0]) seen = 1'b1;
    end
    checkOutput("RMW write phase reached", 32'(seen), 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("async reset pmem_write", 32'(pwrite[0]), 32'd0);
    checkOutput("async reset pmem_read", 32'(pread[0]), 32'd0);
    checkOutput("async reset mem_resp", 32'(mresp[0]), 32'd0);
    checkOutput("async reset pmem_address", 32'(paddr[0]), 32'h0);
    checkOutput("async reset mem_rdata", 32'(mrdata[0]), 32'h0);
    dropInputs(0);
    @(posedge clk); #1;
    reset = 1'b0;
    hold_w[0] = 1'b0;
    force_resp[0] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("stray pmem_resp pmem_write", 32'(pwrite[0]), 32'd0);
      checkOutput("stray pmem_resp mem_resp", 32'(mresp[0]), 32'd0);
    end
    @(posedge clk); #1;
    force_resp[0] = 1'b0;

    // next read works and shows the stalled write never reached memory
    $display("[TB] read after reset");
    expectRead(0, 16'h5000);
    applyStimulus(0, 1'b1, 1'b0, 2'b00, 16'h5000, 16'h0, 2, 16'h1111, 1'b0);

    // RMW disabled: partial store goes straight out as a full word
    $display("[TB] direct partial write, RMW disabled");
    lat[1] = 0;
    expectWrite(1, 16'h2000, 16'h5500);
    applyStimulus(1, 1'b0, 1'b1, 2'b10, 16'h2001, 16'h5500, 2, 16'h0000, 1'b0);

    $display("[TB] read back direct write");
    lat[1] = 1;
    expectRead(1, 16'h2000);
    applyStimulus(1, 1'b1, 1'b0, 2'b00, 16'h2000, 16'h0, 3, 16'h5500, 1'b0);

    repeat (4) @(negedge clk);
    checkOutput("pending reads", rd_q.size(), 0);
    checkOutput("pending writes", wr_q.size(), 0);
    checkOutput("pending responses", resp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
